if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage_pkg.sv | 20 ++
 rtl/if_skid_buf.sv | 37 +++
 rtl/if_fetch_stage.sv | 109 ++++++++++
 tb/tb_if_fetch_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h1C00_0000;
  localparam logic [ILEN-1:0] INST_NOP_DEF = 32'h0340_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  // Sequential fetch increment, wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {valid, pc, inst} holding register used while decode is stalled.
module if_skid_buf
  import if_fetch_stage_pkg::*;
#(
  parameter logic [ILEN-1:0] INST_NOP = INST_NOP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            unload,
  input  logic            flush,
  input  logic [XLEN-1:0] d_pc,
  input  logic [ILEN-1:0] d_inst,
  output logic            q_valid,
  output logic [XLEN-1:0] q_pc,
  output logic [ILEN-1:0] q_inst
);

  fetch_entry_t entry_q;

  // load and unload are mutually exclusive by construction in the parent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      entry_q <= '{pc: '0, inst: INST_NOP};
    end else if (flush || unload) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= 1'b1;
      entry_q <= '{pc: d_pc, inst: d_inst};
    end
  end

  assign q_pc   = entry_q.pc;
  assign q_inst = entry_q.inst;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the fetch PC, drives a 1-cycle IROM and feeds IF/ID
// through a ready/valid handshake; a redirect squashes everything in flight.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [ILEN-1:0] INST_NOP = INST_NOP_DEF
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            jump_en,
  input  logic [XLEN-1:0] npc,
  input  logic            id_ready,
  output logic            irom_en,
  output logic [XLEN-1:0] irom_addr,
  input  logic [ILEN-1:0] irom_inst,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_inst
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            req_q;

  logic            skid_v;
  logic [XLEN-1:0] skid_pc;
  logic [ILEN-1:0] skid_inst;

  logic            out_free;
  logic            resp;
  logic            issue;
  logic [XLEN-1:0] jump_pc;
  logic            unused_npc_lsb;

  assign jump_pc        = {npc[XLEN-1:2], 2'b00};
  assign unused_npc_lsb = ^npc[1:0];

  // Handshake and issue decisions; reset masks the read strobe asynchronously.
  always_comb begin
    out_free  = !if_valid || id_ready;
    resp      = req_q;
    issue     = jump_en || (!skid_v && (!resp || out_free));
    irom_en   = issue && !cpu_rst;
    irom_addr = jump_en ? jump_pc : pc_q;
  end

  // Fetch PC and single outstanding read tracking.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= '0;
    end else if (jump_en) begin
      req_q    <= 1'b1;
      req_pc_q <= jump_pc;
      pc_q     <= pc_incr(jump_pc);
    end else if (issue) begin
      req_q    <= 1'b1;
      req_pc_q <= pc_q;
      pc_q     <= pc_incr(pc_q);
    end else begin
      req_q    <= 1'b0;
    end
  end

  // IF/ID output register; skid content drains ahead of any fresh response.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= INST_NOP;
    end else if (jump_en) begin
      if_valid <= 1'b0;
      if_inst  <= INST_NOP;
    end else if (out_free) begin
      if (skid_v) begin
        if_valid <= 1'b1;
        if_pc    <= skid_pc;
        if_inst  <= skid_inst;
      end else if (resp) begin
        if_valid <= 1'b1;
        if_pc    <= req_pc_q;
        if_inst  <= irom_inst;
      end else begin
        if_valid <= 1'b0;
        if_inst  <= INST_NOP;
      end
    end
  end

  // A response arriving while decode is stalled parks in the skid entry;
  // issue is suppressed that cycle, so skid_v=1 always implies no read in flight.
  if_skid_buf #(
    .INST_NOP (INST_NOP)
  ) u_skid (
    .clk     (cpu_clk),
    .rst     (cpu_rst),
    .load    (!jump_en && !out_free && resp),
    .unload  (!jump_en && out_free && skid_v),
    .flush   (jump_en),
    .d_pc    (req_pc_q),
    .d_inst  (irom_inst),
    .q_valid (skid_v),
    .q_pc    (skid_pc),
    .q_inst  (skid_inst)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: stimulus queues redirect targets,
// a negedge monitor checks every accepted instruction against the PC stream.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h1C00_0000;
  localparam logic [31:0] NOP    = 32'h0340_0000;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        jump_en;
  logic [31:0] npc;
  logic        id_ready;
  logic        irom_en;
  logic [31:0] irom_addr;
  logic [31:0] irom_inst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int          checks;
  int          errors;
  int          xfers;
  logic [31:0] seg_q[$];
  logic [31:0] exp_pc;
  logic        rst_prev;

  if_fetch_stage #(
    .RESET_PC (RST_PC),
    .INST_NOP (NOP)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .jump_en   (jump_en),
    .npc       (npc),
    .id_ready  (id_ready),
    .irom_en   (irom_en),
    .irom_addr (irom_addr),
    .irom_inst (irom_inst),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  // Synchronous-read IROM with one cycle of latency.
  initial irom_inst = 32'h0;
  always @(posedge cpu_clk) if (irom_en) irom_inst <= rom_word(irom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_jump(input logic [31:0] target);
    jump_en = 1'b1;
    npc     = target;
    seg_q.push_back({target[31:2], 2'b00});
  endtask

  // Monitor: transfer happens at the coming edge when if_valid && id_ready.
  initial rst_prev = 1'b0;
  always @(negedge cpu_clk) begin
    if (cpu_rst) begin
      if (!rst_prev) begin
        checks++;
        if (seg_q.size() == 0) begin
          errors++;
          $display("FAIL sb_reset_seg actual=empty expected=queued");
        end else exp_pc = seg_q.pop_front();
      end
    end else begin
      if (!if_valid) check("nop_when_idle", if_inst, NOP);
      if (if_valid && id_ready) begin
        check("sb_pc", if_pc, exp_pc);
        check("sb_inst", if_inst, rom_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        xfers++;
      end
      if (jump_en) begin
        check("jump_en_strobe", 32'(irom_en), 32'd1);
        check("jump_addr", irom_addr, {npc[31:2], 2'b00});
        checks++;
        if (seg_q.size() == 0) begin
          errors++;
          $display("FAIL sb_jump_seg actual=empty expected=queued");
        end else exp_pc = seg_q.pop_front();
      end
    end
    rst_prev = cpu_rst;
  end

  initial begin
    checks = 0; errors = 0; xfers = 0; exp_pc = '0;
    cpu_rst = 1'b1; jump_en = 1'b0; npc = '0; id_ready = 1'b1;
    seg_q.push_back(RST_PC);
    repeat (2) tick();
    check("rst_irom_en", 32'(irom_en), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, NOP);

    // Reset release and first-fetch latency.
    cpu_rst = 1'b0;
    #1;
    check("first_en", 32'(irom_en), 32'd1);
    check("first_addr", irom_addr, RST_PC);
    tick();
    check("edge1_valid", 32'(if_valid), 32'd0);
    check("edge1_addr", irom_addr, RST_PC + 32'd4);
    tick();
    check("edge2_valid", 32'(if_valid), 32'd1);
    check("edge2_pc", if_pc, RST_PC);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_gap_valid", 32'(if_valid), 32'd1);
    end

    // Three-cycle stall: no reads while the skid entry is occupied.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_no_read", 32'(irom_en), 32'd0);
      tick();
      check("stall_valid", 32'(if_valid), 32'd1);
    end
    id_ready = 1'b1;
    repeat (4) tick();

    // Redirect with a read in flight.
    do_jump(32'h1C00_0100);
    tick();
    jump_en = 1'b0;
    check("redir_bubble", 32'(if_valid), 32'd0);
    tick();
    check("redir_target", if_pc, 32'h1C00_0100);
    tick();
    check("redir_next", if_pc, 32'h1C00_0104);

    // Redirect while stalled with a full skid, misaligned target.
    id_ready = 1'b0;
    repeat (2) tick();
    do_jump(32'h1C00_0203);
    #1;
    check("mis_addr", irom_addr, 32'h1C00_0200);
    tick();
    jump_en = 1'b0;
    check("stall_redir_valid", 32'(if_valid), 32'd0);
    check("stall_redir_inst", if_inst, NOP);
    tick();
    check("stall_redir_pc", if_pc, 32'h1C00_0200);
    check("stall_redir_v", 32'(if_valid), 32'd1);
    id_ready = 1'b1;
    repeat (3) tick();

    // Address wrap at the top of the space.
    do_jump(32'hFFFF_FFF8);
    tick();
    jump_en = 1'b0;
    repeat (3) tick();
    check("wrap_pc", if_pc, 32'h0000_0000);
    repeat (3) tick();

    // Asynchronous reset mid-stream with the skid entry full.
    id_ready = 1'b0;
    repeat (2) tick();
    #2;
    seg_q.push_back(RST_PC);
    cpu_rst = 1'b1;
    #1;
    check("async_rst_en", 32'(irom_en), 32'd0);
    check("async_rst_valid", 32'(if_valid), 32'd0);
    check("async_rst_inst", if_inst, NOP);
    id_ready = 1'b1;
    repeat (2) tick();
    cpu_rst = 1'b0;
    tick();
    check("restart_bubble", 32'(if_valid), 32'd0);
    tick();
    check("restart_pc", if_pc, RST_PC);

    // Randomized stalls and redirects.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      r = $urandom();
      id_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        if (r[31:28] == 4'h0) do_jump(32'hFFFF_FFF0 | {28'h0, r[3:0]});
        else do_jump({16'h1C00, r[15:0]});
      end else begin
        jump_en = 1'b0;
      end
      tick();
    end
    jump_en  = 1'b0;
    id_ready = 1'b1;
    repeat (8) tick();

    check("seg_drained", 32'(seg_q.size()), 32'd0);
    checks++;
    if (xfers < 1500) begin
      errors++;
      $display("FAIL throughput actual=%0d expected>=1500", xfers);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
